ir_queue: RTL and testbench

Parametrised instruction register with a built-in prefetch queue. It is the successor to the plain 4-bit latch-on-enable instruction register. Fetched instruction words are accepted over a valid/ready handshake into a DEPTH-entry FIFO. The execute stage then pulls them one at a time into a decoded holding register that presents opcode and operand fields. The block sits between instruction memory fetch and the control unit, and adds flush support for branches.

---
 rtl/ir_queue_if.sv | 30 +++
 rtl/ir_queue.sv | 80 ++++++++
 tb/tb_ir_queue.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ir_queue_if.sv
// Fetch-side handshake, execute-side load request and decoded IR outputs of ir_queue.
// The queue is the slave; fetch and execute logic together form the master.
interface ir_queue_if #(
  parameter int WIDTH = 8,
  parameter int OPC_W = 4,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                   flush;
  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic                   in_ready;
  logic                   ir_load;
  logic                   ir_valid;
  logic [WIDTH-1:0]       ir_out;
  logic [OPC_W-1:0]       opcode;
  logic [WIDTH-OPC_W-1:0] operand;
  logic [CW-1:0]          count;

  modport master (
    output flush, in_valid, in_data, ir_load,
    input  in_ready, ir_valid, ir_out, opcode, operand, count
  );

  modport slave (
    input  flush, in_valid, in_data, ir_load,
    output in_ready, ir_valid, ir_out, opcode, operand, count
  );
endinterface

// File: rtl/ir_queue.sv
// Instruction register fed by a DEPTH-entry prefetch FIFO.
// A load pops the head into the IR; flush empties the queue and invalidates the IR.
module ir_queue #(
  parameter int WIDTH = 8,
  parameter int OPC_W = 4,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  ir_queue_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] ir_out_q, ir_out_d;
  logic             ir_valid_q, ir_valid_d;
  logic             push, pop, in_ready;

  // Registered-state only, so ir_load never reaches in_ready.
  assign in_ready = (count_q < CW'(DEPTH));

  always_comb begin
    push       = bus.in_valid && in_ready && !bus.flush;
    pop        = bus.ir_load && (count_q != '0) && !bus.flush;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ir_out_d   = ir_out_q;
    ir_valid_d = ir_valid_q;
    if (bus.flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      ir_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_d   = rd_ptr_q + AW'(1);
        ir_out_d   = mem_q[rd_ptr_q];
        ir_valid_d = 1'b1;
      end else if (bus.ir_load) begin
        ir_valid_d = 1'b0;
      end
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ir_out_q   <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ir_out_q   <= ir_out_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  // Storage is not reset; count guards every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  assign bus.in_ready = in_ready;
  assign bus.count    = count_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.ir_out   = ir_out_q;
  assign bus.opcode   = ir_out_q[WIDTH-1 -: OPC_W];
  assign bus.operand  = ir_out_q[WIDTH-OPC_W-1:0];
endmodule

// File: tb/tb_ir_queue.sv
// Directed and random checks of ir_queue against a queue-based reference model.
module tb_ir_queue;
  localparam int WIDTH = 8;
  localparam int OPC_W = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ir_queue_if #(.WIDTH(WIDTH), .OPC_W(OPC_W), .DEPTH(DEPTH)) bus ();
  ir_queue #(.WIDTH(WIDTH), .OPC_W(OPC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int pass_cnt = 0;
  int total    = 0;

  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_ir;
  logic             m_vld;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"},    32'(bus.count),    32'(mq.size()));
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(mq.size() < DEPTH));
    check({tag, ".ir_valid"}, 32'(bus.ir_valid), 32'(m_vld));
    check({tag, ".ir_out"},   32'(bus.ir_out),   32'(m_ir));
    check({tag, ".opcode"},   32'(bus.opcode),   32'(m_ir) >> (WIDTH - OPC_W));
    check({tag, ".operand"},  32'(bus.operand),  32'(m_ir) % (32'd1 << (WIDTH - OPC_W)));
  endtask

  task automatic model_reset();
    mq.delete();
    m_ir  = '0;
    m_vld = 1'b0;
  endtask

  // One clock: drive inputs, update the model with the sampled inputs, then compare.
  task automatic step(input string tag, input logic v, input logic [WIDTH-1:0] d,
                      input logic ld, input logic fl);
    bit can_push;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.ir_load  = ld;
    bus.flush    = fl;
    can_push = (mq.size() < DEPTH);
    @(posedge clk);
    if (fl) begin
      mq.delete();
      m_vld = 1'b0;
    end else begin
      if (ld) begin
        if (mq.size() > 0) begin
          m_ir  = mq.pop_front();
          m_vld = 1'b1;
        end else begin
          m_vld = 1'b0;
        end
      end
      if (v && can_push) mq.push_back(d);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    bus.flush = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'hEE; bus.ir_load = 1'b1;

    // Reset held with handshakes active
    repeat (3) begin
      @(posedge clk); #1;
      check_all("reset");
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("reset_release");

    // Fill to full, then offer a 5th word
    step("fill1", 1, 8'h11, 0, 0);
    step("fill2", 1, 8'h22, 0, 0);
    step("fill3", 1, 8'h33, 0, 0);
    step("fill4", 1, 8'h44, 0, 0);
    check("full_count", 32'(bus.count), 32'd4);
    step("fill5_rejected", 1, 8'h55, 0, 0);

    // Drain in order; 5th load is a bubble
    step("drain1", 0, 8'h00, 1, 0);
    check("drain1_first_entry", 32'(bus.ir_out), 32'h11);
    step("drain2", 0, 8'h00, 1, 0);
    step("drain3", 0, 8'h00, 1, 0);
    step("drain4", 0, 8'h00, 1, 0);
    step("drain5_bubble", 0, 8'h00, 1, 0);

    // Streaming push+pop from count=1, wrapping pointers
    step("stream_prime", 1, 8'hA0, 0, 0);
    for (int i = 1; i < 10; i++) step("stream", 1, 8'(8'hA0 + i), 1, 0);
    step("stream_tail", 0, 8'h00, 1, 0);
    check("stream_last", 32'(bus.ir_out), 32'hA9);

    // Flush priority with count=3, ir_valid=1
    step("fl_pre1", 1, 8'h61, 0, 0);
    step("fl_pre2", 1, 8'h62, 0, 0);
    step("fl_pre3", 1, 8'h63, 1, 0);
    step("fl_pre4", 1, 8'h64, 0, 0);
    step("flush", 1, 8'h77, 1, 1);
    check("flush_ir_out_held", 32'(bus.ir_out), 32'h61);
    step("post_flush_push", 1, 8'h88, 0, 0);
    step("post_flush_load", 0, 8'h00, 1, 0);
    step("post_flush_empty", 0, 8'h00, 1, 0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 24) == 0));

    // Asynchronous reset mid-stream
    step("ar_pre1", 1, 8'hC1, 0, 0);
    step("ar_pre2", 1, 8'hC2, 1, 0);
    bus.in_valid = 1'b1; bus.in_data = 8'hC3; bus.ir_load = 1'b1; bus.flush = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    #3;
    check_all("async_reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    step("ar_after1", 1, 8'hD5, 0, 0);
    step("ar_after2", 0, 8'h00, 1, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
